clkgen_div: RTL and testbench
=============================

# clkgen_div

Multi-channel programmable clock divider. It replaces the fixed-period behavioural clock source with synthesizable per-channel divided clocks and tick pulses, all derived from one system clock. Divide ratios and enables can be changed at run time, and every change is applied glitch-free at a period boundary. Consumers are peripheral timing, bus samplers and test-bench stimulus, all of which need slower, aligned strobes.

## Interface
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 8: counter and divide-value width per channel.
- DEF_DIV, 2: active divide ratio for every channel after reset (1..2^CNT_W-1).
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ch_en  input  NUM_CH  per-channel run enable, level-sensitive.
- load  input  1  single-cycle pulse that captures div_val (and hi_val) for all channels.
- div_val  input  NUM_CH*CNT_W  requested divide ratio; channel k occupies bits [k*CNT_W +: CNT_W].
- hi_val  input  NUM_CH*CNT_W  requested high-phase length. This port is present only with CLKGEN_DUTY_EN.
- div_clk  output  NUM_CH  divided clock level, registered.
- tick  output  NUM_CH  one-cycle pulse in the last cycle of each period, registered.
- upd_ack  output  NUM_CH  one-cycle pulse in the first cycle that runs with a newly applied ratio.

## Operation
Each channel has two states, IDLE and RUN, plus the following registers:
- counter cnt
- active ratio act_div
- pending ratio pend_div with flag pend_vld

IDLE:
- cnt=0, div_clk=0, tick=0.
- Transition to RUN when ch_en=1.

RUN:
- cnt counts 0..act_div-1, then wraps to 0.
- div_clk = (cnt < hi), where hi = max(1, act_div>>1).
- tick=1 when cnt==act_div-1.

Disable: when ch_en falls, the channel completes the current period and then enters IDLE. The IDLE entry coincides with the wrap, so there is never a truncated high phase.

Load:
- A load pulse copies div_val into pend_div and sets pend_vld on every channel.
- Pending values are applied at the channel's next wrap, or on the next cycle if the channel is IDLE.
- On apply: act_div takes pend_div, pend_vld clears, and upd_ack pulses in the first cycle of the new period.

Boundary rules:
- div_val=0: the load is ignored for that channel (pend_vld is not set) and the previous ratio is kept.
- act_div=1: div_clk is held at 1 and tick=1 every cycle while in RUN.
- Second load while pend_vld=1: the last value wins, with one upd_ack only.
- Load in the same cycle as a wrap: the new div_val is applied at that wrap directly, bypassing pend_div.
- ch_en falling and load in the same period: the ratio is applied, and the channel goes to IDLE at that wrap. upd_ack still pulses, coincident with the IDLE entry.
- Reset mid-operation: all state returns to reset values immediately and asynchronously, and pending loads are discarded.

Reset values:
- div_clk=0, tick=0, upd_ack=0.
- cnt=0, state IDLE, act_div=DEF_DIV, pend_vld=0.

## Timing
- ch_en sampled high at edge N: RUN begins, and div_clk=1 with cnt=0 is visible after edge N+1.
- Period is exactly act_div clk cycles. With even ratios, duty is 50%; with odd ratios, the high phase is one cycle shorter than the low phase.
- tick is asserted in the same cycle that div_clk is in the last low cycle of the period. tick is 1 cycle wide.
- load to effect: at most act_div cycles in RUN, and 2 cycles in IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- CLKGEN_DUTY_EN defined:
  - The hi_val port exists and is captured and applied together with div_val.
  - div_clk = (cnt < act_hi).
  - act_hi=0 gives div_clk held at 0; act_hi >= act_div gives div_clk held at 1. tick is unaffected in both cases.
- CLKGEN_DUTY_EN undefined:
  - No hi_val port and no hi registers.
  - hi = max(1, act_div>>1).

## Structure
- Package clkgen_pkg holds:
  - enum ch_state_t {IDLE, RUN}
  - default CNT_W and DEF_DIV localparams
  - function calc_hi(div) implementing the max(1, div>>1) rule
- Sub-module clkgen_div_ch: one channel (state, counter, pending logic). It is instantiated NUM_CH times by a generate loop in the top level.
- The top level only slices buses and fans out load.

## Test plan
- Reset with DEF_DIV=2, ch_en=1 from cycle 0 → div_clk toggles every cycle starting one cycle after enable; tick on every second cycle; upd_ack stays 0.
- div_val=5 loaded while running at div 2 → the current period completes, upd_ack pulses once, then div_clk is high for 2 cycles and low for 3, with tick every 5 cycles.
- Two loads (6 then 3) within one period of a div-8 channel → a single upd_ack, and the ratio becomes 3.
- ch_en dropped at cnt=1 on a div-4 channel → 2 more cycles follow, then IDLE with div_clk=0 and no truncated pulse.
- div_val=0 and div_val=1 loaded on two channels → the first keeps its old ratio; the second shows div_clk held at 1 and tick every cycle.
- rst_n asserted mid-period with a pending load → all outputs 0 asynchronously; after release act_div=DEF_DIV and pend_vld=0.

Source files
------------

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: channel state type, default sizing and the default high-phase rule
// shared by clkgen_div and clkgen_div_ch.
package clkgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 2;

  // High-phase length for a ratio: half the period, never below one cycle.
  function automatic logic [31:0] calc_hi(input logic [31:0] div);
    logic [31:0] half;
    half = div >> 1;
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/clkgen_div_ch.sv
// clkgen_div_ch: one divider channel (IDLE/RUN state, period counter, pending ratio).
// With CLKGEN_DUTY_EN defined the high-phase length is programmable through i_hi.
module clkgen_div_ch
  import clkgen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
`ifdef CLKGEN_DUTY_EN
  input  logic [CNT_W-1:0] i_hi,
`endif
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_upd_ack
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  ch_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_act_div, w_act_div_next;
  logic [CNT_W-1:0] r_pend_div, w_pend_div_next;
  logic             r_pend_vld, w_pend_vld_next;
  logic             r_new, w_new_next;
  logic             r_div_clk, r_tick, r_upd_ack;
  logic [CNT_W-1:0] w_hi;
  logic             w_wrap, w_ld, w_apply;

`ifdef CLKGEN_DUTY_EN
  localparam logic [CNT_W-1:0] RST_HI = CNT_W'(calc_hi(32'(DEF_DIV)));
  logic [CNT_W-1:0] r_act_hi, w_act_hi_next;
  logic [CNT_W-1:0] r_pend_hi, w_pend_hi_next;
  assign w_hi = r_act_hi;
`else
  assign w_hi = CNT_W'(calc_hi(32'(r_act_div)));
`endif

  assign w_wrap  = (r_state == RUN) && (r_cnt == r_act_div - ONE);
  assign w_ld    = i_load && (i_div != '0);
  // Ratio changes only land on a period boundary; an idle channel has no period to finish.
  assign w_apply = w_wrap || ((r_state == IDLE) && r_pend_vld);

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_act_div_next  = r_act_div;
    w_pend_div_next = r_pend_div;
    w_pend_vld_next = r_pend_vld;
    w_new_next      = 1'b0;
`ifdef CLKGEN_DUTY_EN
    w_act_hi_next   = r_act_hi;
    w_pend_hi_next  = r_pend_hi;
`endif
    if (w_apply) begin
      w_pend_vld_next = 1'b0;
      w_new_next      = w_ld || r_pend_vld;
      if (w_ld) begin
        w_act_div_next = i_div;
`ifdef CLKGEN_DUTY_EN
        w_act_hi_next  = i_hi;
`endif
      end else if (r_pend_vld) begin
        w_act_div_next = r_pend_div;
`ifdef CLKGEN_DUTY_EN
        w_act_hi_next  = r_pend_hi;
`endif
      end
    end else if (w_ld) begin
      w_pend_div_next = i_div;
      w_pend_vld_next = 1'b1;
`ifdef CLKGEN_DUTY_EN
      w_pend_hi_next  = i_hi;
`endif
    end

    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end
      end
      RUN: begin
        if (w_wrap) begin
          w_cnt_next = '0;
          if (!i_en) w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + ONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_act_div  <= RST_DIV;
      r_pend_div <= '0;
      r_pend_vld <= 1'b0;
      r_new      <= 1'b0;
      r_div_clk  <= 1'b0;
      r_tick     <= 1'b0;
      r_upd_ack  <= 1'b0;
`ifdef CLKGEN_DUTY_EN
      r_act_hi   <= RST_HI;
      r_pend_hi  <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_act_div  <= w_act_div_next;
      r_pend_div <= w_pend_div_next;
      r_pend_vld <= w_pend_vld_next;
      r_new      <= w_new_next;
      // Outputs trail the counter by one cycle so every output is a plain flop.
      r_div_clk  <= (r_state == RUN) && (r_cnt < w_hi);
      r_tick     <= w_wrap;
      r_upd_ack  <= r_new;
`ifdef CLKGEN_DUTY_EN
      r_act_hi   <= w_act_hi_next;
      r_pend_hi  <= w_pend_hi_next;
`endif
    end
  end

  assign o_div_clk = r_div_clk;
  assign o_tick    = r_tick;
  assign o_upd_ack = r_upd_ack;

endmodule

// File: rtl/clkgen_div.sv
// clkgen_div: NUM_CH independent programmable clock dividers sharing one load strobe.
// Define CLKGEN_DUTY_EN to add the hi_val port for programmable high-phase length.
module clkgen_div
  import clkgen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
`ifdef CLKGEN_DUTY_EN
  input  logic [NUM_CH*CNT_W-1:0] hi_val,
`endif
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       upd_ack
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clkgen_div_ch #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (ch_en[gi]),
        .i_load    (load),
        .i_div     (div_val[gi*CNT_W +: CNT_W]),
`ifdef CLKGEN_DUTY_EN
        .i_hi      (hi_val[gi*CNT_W +: CNT_W]),
`endif
        .o_div_clk (div_clk[gi]),
        .o_tick    (tick[gi]),
        .o_upd_ack (upd_ack[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clkgen_div.sv
// tb_clkgen_div: directed scenarios for clkgen_div, checked every cycle against a
// period-level reference model plus hand-computed literal waveforms.
module tb_clkgen_div;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_en;
  logic                    load;
  logic [NUM_CH*CNT_W-1:0] div_val;
`ifdef CLKGEN_DUTY_EN
  logic [NUM_CH*CNT_W-1:0] hi_val;
`endif
  logic [NUM_CH-1:0]       div_clk, tick, upd_ack;

  int vecs   = 0;
  int miscmp = 0;
  int ack_cnt [NUM_CH];

  // Reference model state, on the output timeline: one entry per channel.
  bit m_run [NUM_CH];
  int m_pos [NUM_CH];
  int m_len [NUM_CH];
  int m_act [NUM_CH];
  int m_pd  [NUM_CH];
  bit m_pv  [NUM_CH];
  bit m_ack [NUM_CH];

  clkgen_div #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .load    (load),
    .div_val (div_val),
`ifdef CLKGEN_DUTY_EN
    .hi_val  (hi_val),
`endif
    .div_clk (div_clk),
    .tick    (tick),
    .upd_ack (upd_ack)
  );

  always #5 clk = ~clk;

  function automatic int hi_of(input int d);
    return (d / 2 < 1) ? 1 : d / 2;
  endfunction

  function automatic logic [31:0] pack_acks();
    return {8'(ack_cnt[3]), 8'(ack_cnt[2]), 8'(ack_cnt[1]), 8'(ack_cnt[0])};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want,
                       input bit loud);
    vecs++;
    if (got !== want) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end else if (loud) begin
      $display("check %s: got %0h, expected %0h ok", nm, got, want);
    end
  endtask

  task automatic m_apply(input int c, input bit ld, input int dv);
    if (ld) begin
      m_act[c] = dv; m_pv[c] = 1'b0; m_ack[c] = 1'b1;
    end else if (m_pv[c]) begin
      m_act[c] = m_pd[c]; m_pv[c] = 1'b0; m_ack[c] = 1'b1;
    end
  endtask

  // Model step and compare, 1ns after each rising edge.
  initial begin : model
    logic [NUM_CH-1:0] e_clk, e_tick, e_ack;
    int dv;
    bit en, ld;
    for (int c = 0; c < NUM_CH; c++) ack_cnt[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_run[c] = 1'b0; m_pos[c] = 0; m_len[c] = DEF_DIV; m_act[c] = DEF_DIV;
          m_pd[c] = 0; m_pv[c] = 1'b0; m_ack[c] = 1'b0;
        end
        check("reset_outputs", 32'({div_clk, tick, upd_ack}), 32'd0, 1'b0);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          dv = int'(div_val[c*CNT_W +: CNT_W]);
          en = ch_en[c];
          ld = load && (dv != 0);
          e_ack[c] = m_ack[c];
          m_ack[c] = 1'b0;
          if (m_run[c]) begin
            e_clk[c]  = (m_pos[c] < hi_of(m_len[c]));
            e_tick[c] = (m_pos[c] == m_len[c] - 1);
            if (e_tick[c]) begin
              m_apply(c, ld, dv);
              if (en) begin
                m_pos[c] = 0; m_len[c] = m_act[c];
              end else begin
                m_run[c] = 1'b0;
              end
            end else begin
              m_pos[c]++;
              if (ld) begin m_pd[c] = dv; m_pv[c] = 1'b1; end
            end
          end else begin
            e_clk[c] = 1'b0; e_tick[c] = 1'b0;
            if (m_pv[c]) m_apply(c, ld, dv);
            else if (ld) begin m_pd[c] = dv; m_pv[c] = 1'b1; end
            if (en) begin
              m_run[c] = 1'b1; m_pos[c] = 0; m_len[c] = m_act[c];
            end
          end
        end
        check("model_div_clk", 32'(div_clk), 32'(e_clk), 1'b0);
        check("model_tick", 32'(tick), 32'(e_tick), 1'b0);
        check("model_upd_ack", 32'(upd_ack), 32'(e_ack), 1'b0);
        for (int c = 0; c < NUM_CH; c++) if (upd_ack[c]) ack_cnt[c]++;
      end
    end
  end

  task automatic do_load(input int d0, input int d1, input int d2, input int d3);
    int d [NUM_CH];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int c = 0; c < NUM_CH; c++) begin
      div_val[c*CNT_W +: CNT_W] = CNT_W'(d[c]);
`ifdef CLKGEN_DUTY_EN
      hi_val[c*CNT_W +: CNT_W]  = CNT_W'(hi_of(d[c]));
`endif
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (bounded) for tick or upd_ack of channel c to be seen at a falling edge.
  task automatic wait_for(input string nm, input int c, input bit use_ack);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = use_ack ? upd_ack[c] : tick[c];
    end
    check(nm, 32'(seen), 32'd1, 1'b1);
  endtask

  task automatic capture(input int c, input int n, input bit now,
                         output logic [31:0] s_clk, output logic [31:0] s_tick,
                         output logic [31:0] s_ack);
    s_clk = '0; s_tick = '0; s_ack = '0;
    for (int i = 0; i < n; i++) begin
      if (!(now && i == 0)) @(negedge clk);
      s_clk  = {s_clk[30:0], div_clk[c]};
      s_tick = {s_tick[30:0], tick[c]};
      s_ack  = {s_ack[30:0], upd_ack[c]};
    end
  endtask

  initial begin : stim
    logic [31:0] s_clk, s_tick, s_ack;
    int n;
    rst_n   = 1'b0;
    ch_en   = '1;
    load    = 1'b0;
    div_val = '0;
`ifdef CLKGEN_DUTY_EN
    hi_val  = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Default ratio straight out of reset.
    capture(0, 6, 1'b0, s_clk, s_tick, s_ack);
    check("def_div_clk", s_clk, 32'b010101, 1'b1);
    check("def_tick", s_tick, 32'b001010, 1'b1);
    check("def_upd_ack", s_ack, 32'd0, 1'b1);

    // Ratio 5 on ch0 (8 on ch1, 4 on ch2, 0 ignored on ch3).
    do_load(5, 8, 4, 0);
    wait_for("ack0_after_load", 0, 1'b1);
    capture(0, 10, 1'b1, s_clk, s_tick, s_ack);
    check("div5_clk", s_clk, 32'b1100011000, 1'b1);
    check("div5_tick", s_tick, 32'b0000100001, 1'b1);
    check("div5_ack", s_ack, 32'b1000000000, 1'b1);
    repeat (12) @(negedge clk);
    check("acks_first_load", pack_acks(), 32'h00010101, 1'b1);

    // Two loads inside one div-8 period on ch1; ch3 gets ratio 1.
    wait_for("tick1_div8", 1, 1'b0);
    do_load(0, 6, 0, 1);
    @(negedge clk);
    do_load(0, 3, 0, 0);
    repeat (16) @(negedge clk);
    check("acks_double_load", pack_acks(), 32'h01010201, 1'b1);
    wait_for("tick1_div3", 1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[1] && n < 20);
    check("div3_period", 32'(n), 32'd3, 1'b1);
    capture(3, 4, 1'b0, s_clk, s_tick, s_ack);
    check("div1_clk", s_clk, 32'b1111, 1'b1);
    check("div1_tick", s_tick, 32'b1111, 1'b1);

    // Disable the div-4 channel one cycle into a period.
    wait_for("tick2_div4", 2, 1'b0);
    @(negedge clk);
    ch_en[2] = 1'b0;
    capture(2, 6, 1'b0, s_clk, s_tick, s_ack);
    check("disable_clk", s_clk, 32'b100000, 1'b1);
    check("disable_tick", s_tick, 32'b001000, 1'b1);

    // Load into an idle channel: acknowledged two cycles later.
    do_load(0, 0, 6, 0);
    s_ack = 32'(upd_ack[2]);
    @(negedge clk);
    s_ack = {s_ack[30:0], upd_ack[2]};
    @(negedge clk);
    s_ack = {s_ack[30:0], upd_ack[2]};
    check("idle_load_ack", s_ack, 32'b001, 1'b1);
    ch_en[2] = 1'b1;

    // Drop enable and load in the same period of the div-5 channel.
    wait_for("tick0_div5", 0, 1'b0);
    ch_en[0] = 1'b0;
    do_load(2, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("idle_after_disable", 32'(div_clk[0]), 32'd0, 1'b1);
    check("acks_disable_load", pack_acks(), 32'h01020202, 1'b1);
    ch_en[0] = 1'b1;

    // Asynchronous reset while ch1 holds a pending load.
    repeat (4) @(negedge clk);
    wait_for("tick1_div3_b", 1, 1'b0);
    do_load(0, 7, 0, 0);
    check("pre_reset_clk3", 32'(div_clk[3]), 32'd1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({div_clk, tick, upd_ack}), 32'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    capture(1, 6, 1'b0, s_clk, s_tick, s_ack);
    check("post_reset_clk", s_clk, 32'b010101, 1'b1);
    check("post_reset_tick", s_tick, 32'b001010, 1'b1);
    repeat (20) @(negedge clk);
    check("pending_discarded", 32'(ack_cnt[1]), 32'd2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
